// File: rtl/mmio_uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// serialiser state encoding and STATUS word layout.
package mmio_uart_pkg;

    // Register offsets within the 4-word window
    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_DROPCNT = 2'd2;
    localparam logic [1:0] OFF_RSVD    = 2'd3;

    // Serialiser states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // STATUS word layout: {22'b0, count[7:0], full, empty}
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_COUNT_LSB = 2;
    localparam int STAT_COUNT_W   = 8;

    // Drop counter saturates here
    localparam logic [7:0] DROP_MAX = 8'hFF;

    function automatic logic [31:0] pack_status(input logic [7:0] count,
                                                input logic       full,
                                                input logic       empty);
        logic [31:0] word;
        word                                  = '0;
        word[STAT_EMPTY_BIT]                  = empty;
        word[STAT_FULL_BIT]                   = full;
        word[STAT_COUNT_LSB +: STAT_COUNT_W]  = count;
        return word;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous circular-buffer FIFO. A push is refused when full, regardless
// of a pop in the same cycle; a pop is ignored when empty.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; stale entries are harmless because empty gates every read
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting beside data RAM on the
// processor's dmem bus. Stores to TXDATA queue bytes; loads return STATUS
// and the drop counter with the same one-cycle latency as RAM.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high; pops the next byte as soon as the FIFO has one
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high) for CLKS_PER_BIT cycles, then back to IDLE
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR    = 12'hF00,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    output logic [31:0] q_dmem,
    output logic        sel_q,
    output logic        tx,
    output logic        irq_empty
);

    localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int              BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]   BCNT_LAST = BW'(CLKS_PER_BIT - 1);

    logic          hit;
    logic [1:0]    off;
    logic          push_req;
    logic          clr_req;
    logic          drop_evt;
    logic [7:0]    drop;
    logic [31:0]   regval;

    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [8:0]    count_ext;

    tx_state_t     state;
    logic [BW-1:0] bcnt;
    logic [2:0]    bidx;
    logic [7:0]    shreg;

    logic          unused_bits;

    // Address decode: only the word-aligned 4-word window responds
    assign hit      = (address_dmem[11:2] == BASE_ADDR[11:2]);
    assign off      = address_dmem[1:0];
    assign push_req = wren && hit && (off == OFF_TXDATA);
    assign clr_req  = wren && hit && (off == OFF_DROPCNT);
    assign drop_evt = push_req && fifo_full;
    assign fifo_pop = (state == IDLE) && !fifo_empty;

    // Count is at most 9 bits wide; STATUS only exposes the low 8
    assign count_ext   = 9'(fifo_count);
    assign unused_bits = ^{data[31:8], count_ext[8]};

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .wdata (data[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Register read mux, reflecting state before this edge's update
    always_comb begin
        regval = '0;
        case (off)
            OFF_STATUS:  regval = pack_status(count_ext[7:0], fifo_full, fifo_empty);
            OFF_DROPCNT: regval = {24'b0, drop};
            default:     regval = '0;
        endcase
    end

    // Registered load path: same one-cycle latency as RAM, zero when not selected
    always_ff @(posedge clock) begin
        if (reset) begin
            q_dmem <= '0;
            sel_q  <= 1'b0;
        end else begin
            q_dmem <= hit ? regval : '0;
            sel_q  <= hit;
        end
    end

    // Drop counter: saturating; a clear coinciding with a drop leaves one drop counted
    always_ff @(posedge clock) begin
        if (reset) begin
            drop <= '0;
        end else if (clr_req) begin
            drop <= drop_evt ? 8'd1 : 8'd0;
        end else if (drop_evt && (drop != DROP_MAX)) begin
            drop <= drop + 8'd1;
        end
    end

    // Empty interrupt, registered from the current FIFO and FSM state
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_empty <= 1'b1;
        end else begin
            irq_empty <= fifo_empty && (state == IDLE);
        end
    end

    // Serialiser: tx is driven from a flop so the line never glitches
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            bcnt  <= '0;
            bidx  <= '0;
            shreg <= '0;
            tx    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    bcnt <= '0;
                    bidx <= '0;
                    if (fifo_pop) begin
                        shreg <= fifo_rdata;
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (bcnt == BCNT_LAST) begin
                        bcnt  <= '0;
                        bidx  <= '0;
                        state <= DATA;
                        tx    <= shreg[0];
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bcnt == BCNT_LAST) begin
                        bcnt <= '0;
                        if (bidx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bidx <= bidx + 3'd1;
                            tx   <= shreg[bidx + 3'd1];
                        end
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bcnt == BCNT_LAST) begin
                        bcnt  <= '0;
                        state <= IDLE;
                        tx    <= 1'b1;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
// Bench for mmio_uart_tx: a reference occupancy model pushes every accepted
// byte into a scoreboard; a line monitor decodes frames and pops/compares.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [11:0] BASE  = 12'hF00;
    localparam logic [11:0] NOHIT = 12'h100;
    localparam int          FRAME = 10 * CPB;

    logic        clock = 1'b0;
    logic        reset;
    logic        wren;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_dmem;
    logic        sel_q;
    logic        tx;
    logic        irq_empty;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          frames_done = 0;
    int          start_q[$];
    logic [7:0]  sb[$];

    int          m_cnt   = 0;
    int          m_timer = 0;
    logic        m_acc;
    logic        m_pop;

    int          mon_start;
    int          mon_bit;
    logic        mon_abort;
    logic [7:0]  mon_byte;

    int          fb;
    int          lowcnt;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wren         (wren),
        .address_dmem (address_dmem),
        .data         (data),
        .q_dmem       (q_dmem),
        .sel_q        (sel_q),
        .tx           (tx),
        .irq_empty    (irq_empty)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: FIFO occupancy and transmitter busy time
    assign m_acc = wren && (address_dmem == BASE) && (m_cnt < DEPTH);
    assign m_pop = (m_timer == 0) && (m_cnt > 0);

    always @(posedge clock) begin
        if (reset) begin
            m_cnt   <= 0;
            m_timer <= 0;
            sb.delete();
        end else begin
            if (m_acc) sb.push_back(data[7:0]);
            m_cnt   <= m_cnt + (m_acc ? 1 : 0) - (m_pop ? 1 : 0);
            m_timer <= m_pop ? FRAME : ((m_timer > 0) ? m_timer - 1 : 0);
        end
    end

    // Line monitor: decode each frame at bit centres
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && tx === 1'b0) begin
                mon_start = cyc;
                mon_abort = 1'b0;
                mon_byte  = '0;
                for (int i = 1; i <= 9 * CPB + CPB / 2; i++) begin
                    @(negedge clock);
                    if (reset) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    if ((i % CPB) == CPB / 2) begin
                        mon_bit = i / CPB;
                        if (mon_bit == 0)      check_val("start_bit", 32'(tx), 32'd0);
                        else if (mon_bit <= 8) mon_byte[mon_bit-1] = tx;
                        else                   check_val("stop_bit", 32'(tx), 32'd1);
                    end
                end
                if (!mon_abort) begin
                    frames_done++;
                    start_q.push_back(mon_start);
                    if (sb.size() == 0) check_val("rx_unexpected_frame", 32'(mon_byte), 32'hFFFF_FFFF);
                    else                check_val("rx_byte", 32'(mon_byte), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [11:0] a, input logic [31:0] d);
        address_dmem = a;
        data         = d;
        wren         = 1'b1;
        tick();
        wren         = 1'b0;
        address_dmem = NOHIT;
        data         = '0;
    endtask

    task automatic load(input string tag, input logic [11:0] a,
                        input logic [31:0] exp_q, input logic exp_sel);
        address_dmem = a;
        wren         = 1'b0;
        tick();
        address_dmem = NOHIT;
        check_val({tag, "_q"}, q_dmem, exp_q);
        check_val({tag, "_sel"}, 32'(sel_q), 32'(exp_sel));
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (irq_empty === 1'b1 && sb.size() == 0) break;
            tick();
        end
        check_val({tag, "_drain_sb"}, sb.size(), 0);
        check_val({tag, "_drain_irq"}, 32'(irq_empty), 32'd1);
    endtask

    function automatic logic exp_tx(input int j, input logic [7:0] b);
        int k;
        if (j < 1 || j > FRAME) return 1'b1;
        k = (j - 1) / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        reset        = 1'b1;
        wren         = 1'b0;
        address_dmem = NOHIT;
        data         = '0;

        // Reset state
        tick();
        check_val("rst_tx", 32'(tx), 32'd1);
        check_val("rst_q", q_dmem, 32'd0);
        check_val("rst_sel", 32'(sel_q), 32'd0);
        check_val("rst_irq", 32'(irq_empty), 32'd1);
        tick();
        reset = 1'b0;
        load("rst_status", BASE + 12'd1, 32'h1, 1'b1);
        load("rst_drop", BASE + 12'd2, 32'h0, 1'b1);
        load("rst_rsvd", BASE + 12'd3, 32'h0, 1'b1);

        // Single byte, cycle-exact waveform and interrupt
        fb = frames_done;
        store(BASE, 32'h55);
        for (int j = 0; j <= 44; j++) begin
            check_val($sformatf("t1_tx_%0d", j), 32'(tx), 32'(exp_tx(j, 8'h55)));
            check_val($sformatf("t1_irq_%0d", j), 32'(irq_empty),
                      32'((j == 0 || j >= FRAME + 2) ? 1 : 0));
            tick();
        end
        wait_drain("t1", 200);
        check_val("t1_frames", frames_done - fb, 1);

        // Back-to-back: exactly one idle cycle between frames
        fb = frames_done;
        store(BASE, 32'hA5);
        store(BASE, 32'h3C);
        wait_drain("t2", 300);
        check_val("t2_frames", frames_done - fb, 2);
        if (frames_done - fb == 2)
            check_val("t2_gap", start_q[fb+1] - start_q[fb], FRAME + 1);

        // Overflow: five accepted, sixth dropped
        fb = frames_done;
        for (int i = 1; i <= 6; i++) store(BASE, 32'(i));
        load("t3_status_full", BASE + 12'd1, 32'h12, 1'b1);
        load("t3_drop1", BASE + 12'd2, 32'h1, 1'b1);
        store(BASE + 12'd2, 32'hFFFF_FFFF);
        load("t3_drop_cleared", BASE + 12'd2, 32'h0, 1'b1);
        wait_drain("t3", 600);
        check_val("t3_frames", frames_done - fb, 5);

        // Status with three queued, writes to non-push offsets and non-hit addresses
        for (int i = 0; i < 4; i++) store(BASE, 32'(8'hC0 + i));
        load("t4_status", BASE + 12'd1, 32'hC, 1'b1);
        load("t4_txdata_rd", BASE, 32'h0, 1'b1);
        load("t4_rsvd_rd", BASE + 12'd3, 32'h0, 1'b1);
        load("t4_nohit", NOHIT, 32'h0, 1'b0);
        store(BASE + 12'd1, 32'hFF);
        store(BASE + 12'd3, 32'hFF);
        store(12'hE00, 32'h77);
        store(12'h0F0, 32'h77);
        load("t4_status_after", BASE + 12'd1, 32'hC, 1'b1);
        load("t4_drop_after", BASE + 12'd2, 32'h0, 1'b1);
        wait_drain("t4", 600);

        // Reset mid-frame, in data bit 3 of 0x81, with a same-cycle push
        store(BASE, 32'h81);
        store(BASE, 32'h22);
        store(BASE, 32'h33);
        repeat (15) tick();
        check_val("t5_bit3", 32'(tx), 32'd0);
        reset        = 1'b1;
        wren         = 1'b1;
        address_dmem = BASE;
        data         = 32'h99;
        tick();
        reset        = 1'b0;
        wren         = 1'b0;
        address_dmem = NOHIT;
        check_val("t5_tx", 32'(tx), 32'd1);
        check_val("t5_q", q_dmem, 32'd0);
        check_val("t5_sel", 32'(sel_q), 32'd0);
        load("t5_status", BASE + 12'd1, 32'h1, 1'b1);
        fb     = frames_done;
        lowcnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx !== 1'b1) lowcnt++;
            tick();
        end
        check_val("t5_tx_low_cycles", lowcnt, 0);
        check_val("t5_frames", frames_done - fb, 0);
        check_val("t5_sb", sb.size(), 0);

        // Saturation, then a clear followed by a drop
        for (int i = 0; i < 300; i++) store(BASE, 32'(i));
        load("t6_drop_sat", BASE + 12'd2, 32'hFF, 1'b1);
        store(BASE + 12'd2, 32'h0);
        store(BASE, 32'hEE);
        load("t6_drop_one", BASE + 12'd2, 32'h1, 1'b1);
        wait_drain("t6", 2000);
        load("t6_status_end", BASE + 12'd1, 32'h1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
